// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte writer/receiver pair: bus bit positions,
// receiver state encoding and the default word width.
package spi_pkg;

  localparam int SPI_NCS    = 2;
  localparam int SPI_SCLK   = 1;
  localparam int SPI_MOSI   = 0;
  localparam int SPI_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Read port of the SPI byte receiver: the receiver (master) offers a word,
// the consumer (slave) takes it.
// Handshake: the consumer may raise EN_read in any cycle. It has an effect only
// when RDY_read is 1, and the word on read is consumed at that rising CLK edge.
// read holds its value until a newer word replaces it.
interface spi_byte_receiver_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);
  logic              EN_read;
  logic [DATA_W-1:0] read;
  logic              RDY_read;

  modport master (
    input  EN_read,
    output read,
    output RDY_read
  );

  modport slave (
    output EN_read,
    input  read,
    input  RDY_read
  );
endinterface

// File: rtl/spi_sclk_edge.sv
// Registers sclk once per CLK and flags the cycle in which it goes 0 -> 1.
module spi_sclk_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic rise
);
  logic sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= sclk;
    end
  end

  assign rise = sclk & ~sclk_q;
endmodule

// File: rtl/spi_byte_receiver.sv
// Deserialises MSB-first SPI bits into words and buffers one word for a
// ready/enable consumer, flagging overrun (sticky) and framing errors (pulse).
module spi_byte_receiver
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int CNT_W  = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [2:0]           spi,
  spi_byte_receiver_if.master  rd,
  output logic                 overrun,
  output logic                 frame_err,
  output rx_state_t            state_dbg
);
  logic              ncs;
  logic              mosi;
  logic              rise;
  logic              done;
  logic              take;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt;
  rx_state_t         state;

  assign ncs  = spi[SPI_NCS];
  assign mosi = spi[SPI_MOSI];

  spi_sclk_edge u_sclk_edge (
    .clk   (CLK),
    .rst_n (RST_N),
    .sclk  (spi[SPI_SCLK]),
    .rise  (rise)
  );

  // A deasserting ncs outranks a simultaneous sclk rise, so done needs ncs low.
  assign done      = (state == SHIFT) && !ncs && rise && (cnt == CNT_W'(DATA_W - 1));
  assign take      = rd.EN_read && rd.RDY_read;
  assign word      = {sh[DATA_W-2:0], mosi};
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      rd.read     <= '0;
      rd.RDY_read <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          sh  <= '0;
          cnt <= '0;
          if (!ncs) state <= SHIFT;
        end
        SHIFT: begin
          if (ncs) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            frame_err <= (cnt != '0);
          end else if (rise) begin
            sh  <= word;
            cnt <= done ? '0 : cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (take) overrun <= 1'b0;

      // A word completing alongside a read refills the buffer instead of emptying it.
      if (done) begin
        if (!rd.RDY_read || rd.EN_read) begin
          rd.read     <= word;
          rd.RDY_read <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (take) begin
        rd.RDY_read <= 1'b0;
      end
    end
  end
endmodule
